// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scancode sequencer: tracks E0/F0 prefixes, maps six game keys to press/release
// events in a FIFO with valid/ready handshake. Optional macro: PS2_TYPEMATIC_EN.
module ps2_key_event_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK_50,
  input  logic       RESET_N,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       rx_err,
  input  logic       evt_ready,
  input  logic       ovf_clr,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic       evt_release,
  output logic [5:0] key_held,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

`ifdef PS2_TYPEMATIC_EN
  localparam bit TYPEMATIC = 1'b1;
`else
  localparam bit TYPEMATIC = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t      state_q, state_d;
  logic        lookup;
  logic        is_ext, is_brk;
  logic        key_hit;
  logic [2:0]  key_code;
  logic        evt_gen;
  logic [5:0]  held_d;

  logic [3:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count_q;
  logic        full, pop, push_ok, drop;

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A non-prefix byte is looked up with the prefixes seen so far, then the FSM returns to IDLE.
  always_comb begin
    state_d = state_q;
    lookup  = 1'b0;
    is_ext  = (state_q == EXT) || (state_q == EXT_BRK);
    is_brk  = (state_q == BRK) || (state_q == EXT_BRK);
    if (rx_err) begin
      state_d = IDLE;
    end else if (rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (rx_byte == 8'hE0)      state_d = EXT;
          else if (rx_byte == 8'hF0) state_d = BRK;
          else begin lookup = 1'b1; state_d = IDLE; end
        end
        EXT: begin
          if (rx_byte == 8'hF0)      state_d = EXT_BRK;
          else if (rx_byte == 8'hE0) state_d = EXT;
          else begin lookup = 1'b1; state_d = IDLE; end
        end
        BRK: begin
          if (rx_byte == 8'hF0) state_d = BRK;
          else begin lookup = 1'b1; state_d = IDLE; end
        end
        EXT_BRK: begin
          if (rx_byte == 8'hF0) state_d = EXT_BRK;
          else begin lookup = 1'b1; state_d = IDLE; end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Arrow codes only count with E0; without it they are keypad keys.
  always_comb begin
    key_hit  = 1'b0;
    key_code = 3'd0;
    unique case (rx_byte)
      8'h75:   begin key_hit = is_ext; key_code = 3'd0; end
      8'h72:   begin key_hit = is_ext; key_code = 3'd1; end
      8'h6B:   begin key_hit = is_ext; key_code = 3'd2; end
      8'h74:   begin key_hit = is_ext; key_code = 3'd3; end
      8'h29:   begin key_hit = 1'b1;   key_code = 3'd4; end
      8'h5A:   begin key_hit = 1'b1;   key_code = 3'd5; end
      default: begin key_hit = 1'b0;   key_code = 3'd0; end
    endcase
  end

  always_comb begin
    held_d  = key_held;
    evt_gen = 1'b0;
    if (lookup && key_hit) begin
      if (is_brk) evt_gen = key_held[key_code];
      else        evt_gen = !key_held[key_code] || TYPEMATIC;
      held_d[key_code] = !is_brk;
    end
  end

  assign full    = (count_q == DEPTH_C);
  assign pop     = evt_valid && evt_ready;
  assign push_ok = evt_gen && (!full || pop);
  assign drop    = evt_gen && full && !pop;

  assign evt_valid = (count_q != '0);
  assign {evt_release, evt_code} = mem[rd_ptr];

  // A pop in the same cycle frees a slot, so a full FIFO can still accept the push.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 4'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      key_held <= 6'd0;
      overflow <= 1'b0;
    end else begin
      key_held <= held_d;
      if (push_ok) begin
        mem[wr_ptr] <= {is_brk, key_code};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Scoreboard bench for ps2_key_event_ctrl: a prefix/held-key model predicts events,
// a negedge monitor pops and compares them. Honours PS2_TYPEMATIC_EN.
module tb_ps2_key_event_ctrl;

  localparam int D = 4;
`ifdef PS2_TYPEMATIC_EN
  localparam bit TYP = 1'b1;
`else
  localparam bit TYP = 1'b0;
`endif

  logic       CLK_50 = 1'b0;
  logic       RESET_N = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_release;
  logic [5:0] key_held;
  logic       overflow;

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [3:0] exp_q[$];
  logic [5:0] m_held = 6'd0;
  bit         m_ovf = 1'b0;
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;

  ps2_key_event_ctrl #(.FIFO_DEPTH(D)) dut (
    .CLK_50(CLK_50), .RESET_N(RESET_N), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_err(rx_err), .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(evt_valid),
    .evt_code(evt_code), .evt_release(evt_release), .key_held(key_held), .overflow(overflow)
  );

  always #10 CLK_50 = ~CLK_50;

  task automatic checkOutput(input string name, input int got, input int expv);
    check_cnt++;
    if (got == expv) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
  endtask

  function automatic int keyOf(input logic [7:0] b, input bit ext);
    if (b == 8'h29) return 4;
    if (b == 8'h5A) return 5;
    if (ext) begin
      if (b == 8'h75) return 0;
      if (b == 8'h72) return 1;
      if (b == 8'h6B) return 2;
      if (b == 8'h74) return 3;
    end
    return -1;
  endfunction

  // Reference behaviour for one clock edge; sz is the queue size seen before the edge.
  task automatic modelStep(input logic [7:0] b, input logic v, e, r, c, input int sz);
    int  k;
    int  ev;
    bit  popped;
    bit  dropped;
    ev = -1;
    popped = r && (sz > 0);
    dropped = 1'b0;
    if (e) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (v) begin
      if (b == 8'hE0 && !m_brk) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        k = keyOf(b, m_ext);
        if (k >= 0) begin
          if (m_brk) begin
            if (m_held[k]) begin m_held[k] = 1'b0; ev = 8 + k; end
          end else begin
            if (!m_held[k] || TYP) ev = k;
            m_held[k] = 1'b1;
          end
        end
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end
    if (ev >= 0) begin
      if (sz < D || popped) exp_q.push_back(4'(ev));
      else dropped = 1'b1;
    end
    if (dropped) m_ovf = 1'b1;
    else if (c)  m_ovf = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic v, e, r, c);
    int sz;
    rx_byte = b; rx_valid = v; rx_err = e; evt_ready = r; ovf_clr = c;
    sz = exp_q.size();
    @(posedge CLK_50); #1;
    modelStep(b, v, e, r, c, sz);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic r);
    applyStimulus(b, 1'b1, 1'b0, r, 1'b0);
  endtask

  task automatic idleCycles(input int n, input logic r);
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, 1'b0, r, 1'b0);
  endtask

  task automatic doReset();
    RESET_N = 1'b0;
    rx_valid = 1'b0; rx_err = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
    exp_q.delete();
    m_held = 6'd0; m_ovf = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
    @(negedge CLK_50);
    checkOutput("reset_evt_code", int'(evt_code), 0);
    checkOutput("reset_evt_release", int'(evt_release), 0);
    @(posedge CLK_50); #1;
    RESET_N = 1'b1;
  endtask

  // Monitor: status every cycle, event payload whenever the consumer takes the head.
  always @(negedge CLK_50) begin
    logic [3:0] expv;
    checkOutput("evt_valid", int'(evt_valid), int'(exp_q.size() > 0));
    checkOutput("key_held", int'(key_held), int'(m_held));
    checkOutput("overflow", int'(overflow), int'(m_ovf));
    if (evt_ready && exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      checkOutput("evt_data", int'({evt_release, evt_code}), int'(expv));
    end
  end

  logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h5A, 8'hAA, 8'hE0};

  initial begin
    doReset();

    sendByte(8'hE0, 1); sendByte(8'h75, 1);
    sendByte(8'hE0, 1); sendByte(8'hF0, 1); sendByte(8'h75, 1);
    idleCycles(3, 1);

    sendByte(8'h75, 1); sendByte(8'hF0, 1); sendByte(8'h75, 1);
    sendByte(8'hE0, 1); sendByte(8'h5A, 1);
    idleCycles(3, 1);

    sendByte(8'h29, 1); sendByte(8'h29, 1); sendByte(8'h29, 1);
    sendByte(8'hF0, 1); sendByte(8'h29, 1);
    idleCycles(3, 1);

    doReset();
    sendByte(8'hE0, 0); sendByte(8'h75, 0);
    sendByte(8'hE0, 0); sendByte(8'h72, 0);
    sendByte(8'hE0, 0); sendByte(8'h6B, 0);
    sendByte(8'hE0, 0); sendByte(8'h74, 0);
    sendByte(8'h29, 0);
    idleCycles(2, 0);
    idleCycles(6, 1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    idleCycles(2, 1);

    doReset();
    sendByte(8'hE0, 1);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    sendByte(8'h75, 1);
    applyStimulus(8'hE0, 1'b1, 1'b1, 1'b1, 1'b0);
    sendByte(8'h74, 1);
    idleCycles(2, 1);

    sendByte(8'hF0, 1);
    doReset();
    sendByte(8'h29, 1);
    idleCycles(3, 1);

    for (int i = 0; i < 800; i++) begin
      applyStimulus(pool[$urandom_range(0, 9)],
                    $urandom_range(0, 99) < 65,
                    $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 85),
                    $urandom_range(0, 99) < 5);
    end
    idleCycles(D + 4, 1);
    checkOutput("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

Sequencer between the PS/2 byte receiver and the game logic. It consumes validated scancode bytes, tracks E0 (extended) and F0 (break) prefixes, and maps the six game keys (arrows, space, enter) to press/release events. It keeps a held-key bitmap and buffers events in a small FIFO with a valid/ready handshake, so game logic can consume them at its own pace.

## Interface
- FIFO_DEPTH, 4: event FIFO entries; power of two, minimum 2.
- CLK_50  in  1  50 MHz system clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- rx_byte  in  8  received scancode byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle pulse per received byte (CLK_50 domain).
- rx_err  in  1  one-cycle pulse on a parity or framing error from the receiver.
- evt_ready  in  1  consumer accepts the head event when evt_valid=1.
- ovf_clr  in  1  clears the overflow flag.
- evt_valid  out  1  FIFO not empty.
- evt_code  out  3  head event key: 0 up, 1 down, 2 left, 3 right, 4 space, 5 enter.
- evt_release  out  1  head event type: 1 release, 0 press.
- key_held  out  6  held-key bitmap; bit index equals key code.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.

## Operation
- Prefix FSM has four states: IDLE, EXT, BRK, EXT_BRK. It advances only on rx_valid=1.
  - IDLE: E0 goes to EXT; F0 goes to BRK; any other byte is looked up as (ext=0, brk=0), then IDLE.
  - EXT: F0 goes to EXT_BRK; E0 stays in EXT; any other byte is looked up as (ext=1, brk=0), then IDLE.
  - BRK: F0 stays in BRK; any other byte is looked up as (ext=0, brk=1), then IDLE.
  - EXT_BRK: F0 stays in EXT_BRK; any other byte is looked up as (ext=1, brk=1), then IDLE.
- Lookup table:
  - E0-prefixed 75/72/6B/74 map to up/down/left/right.
  - 29 maps to space; 5A maps to enter, with or without E0.
  - Unprefixed 75/72/6B/74 are keypad keys and produce nothing.
  - All other bytes (AA, FA, E1, …) produce nothing.
- Press on a key that is not held: set its key_held bit and push {0, code}.
- Press on a key already held (typematic repeat): behaviour depends on the macro; see Configuration.
- Release on a held key: clear its key_held bit and push {1, code}.
- Release on a key that is not held: no event and no state change.
- rx_err: FSM returns to IDLE and any pending prefix is discarded. If rx_err and rx_valid occur in the same cycle, the error wins and the byte is dropped.
- FIFO behaviour:
  - Head is presented on evt_code/evt_release.
  - Pop happens when evt_valid and evt_ready are both 1.
  - Full with no pop in the same cycle: the event is dropped and overflow is set. key_held still updates.
  - Full with a pop in the same cycle: the push succeeds.
  - Empty: evt_code and evt_release hold their last value and are don't-care.
- overflow clears on ovf_clr. If ovf_clr and a new drop occur in the same cycle, set wins.
- Reset (any time, including mid-sequence): FSM=IDLE, FIFO empty, evt_valid=0, evt_code=0, evt_release=0, key_held=0, overflow=0.

## Timing
- A byte sampled with rx_valid at edge N updates FSM, key_held and FIFO at edge N. evt_valid rises after edge N when the FIFO was empty, giving 1-cycle latency.
- Back-to-back rx_valid on consecutive cycles is supported at full rate.
- A pop at edge N exposes the next entry after edge N. With the FIFO continuously fed and drained, evt_valid stays high.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.

## Configuration
- PS2_TYPEMATIC_EN defined: a press on an already-held key pushes another {0, code} event (auto-repeat for menus).
- PS2_TYPEMATIC_EN undefined: a press on an already-held key produces no event. Only the first press and the release are reported.
- key_held behaviour is identical in both builds.

## Test plan
- E0,75 then E0,F0,75 with evt_ready=1 -> events {0,0} then {1,0}; key_held goes 000001 then 000000.
- 75, then F0,75, without E0 -> no events; key_held=0. Then E0,5A -> event {0,5}; key_held=100000.
- 29,29,29 then F0,29: without macro -> {0,4},{1,4}; with PS2_TYPEMATIC_EN -> {0,4}×3, then {1,4}.
- evt_ready=0, press up, down, left, right, space -> 4 entries, overflow=1, key_held=011111. Draining returns codes 0,1,2,3 in order. ovf_clr -> overflow=0.
- E0, then rx_err pulse, then 75 -> no event; FSM ends in IDLE.
- F0 received, then RESET_N low for 1 cycle, then 29 -> all outputs zero after reset; 29 yields press {0,4}, not a release.
